act_unit_scheduler: RTL and testbench
=====================================

Name: act_unit_scheduler

Overview:
Time-multiplexes one shared combinational sigmoid unit among N_REQ GRU gate requesters: the reset gate, the update gate and the candidate-state path.
Each request asks for either a sigmoid or a tanh of one Q3.4 operand.
Tanh is derived on the same sigmoid unit as tanh(x) = 2*sigmoid(2x) - 1.0, with pre-scaling and post-processing done here.
Requests are arbitrated round-robin, pass through a 2-stage pipeline with valid/ready backpressure, and each result is returned tagged with the requester id.

Parameters:
DATA_WIDTH, 8, operand/result width; signed fixed point with 4 fractional bits, so 1.0 = 0x10.
N_REQ, 3, number of requesters; legal range 2..8.
ID_W, 2, requester id width; must satisfy 2**ID_W >= N_REQ.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  N_REQ  per-requester request valid.
req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
req_op  in  N_REQ  per-requester op: 0 = sigmoid, 1 = tanh.
req_data  in  N_REQ*DATA_WIDTH  packed operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
rsp_valid  out  1  result valid.
rsp_ready  in  1  result consumer ready.
rsp_data  out  DATA_WIDTH  signed result.
rsp_id  out  ID_W  requester index of the result.
rsp_op  out  1  op of the result.
sig_in  out  DATA_WIDTH  operand driven to the shared sigmoid unit.
sig_out  in  DATA_WIDTH  sigmoid unit result; combinational from sig_in, range 0x00..0x10.
busy  out  1  high while either pipeline stage holds a valid entry.
op_count  out  CNT_W  number of completed response handshakes; saturates at all-ones.

Behaviour:
- Reset, asynchronous, active-high:
  - s1_valid = 0, rsp_valid = 0.
  - rsp_data, rsp_id, rsp_op, sig_in = 0.
  - RR pointer = N_REQ-1, so requester 0 has first priority.
  - op_count = 0, busy = 0.
  - Reset mid-operation drops all in-flight ops; no response is produced for them.
- Stall and accept:
  - stall = rsp_valid & ~rsp_ready.
  - can_accept = ~stall & (~s1_valid | ~rsp_valid | rsp_ready). Since stall covers the last term, this reduces to can_accept = ~stall.
- Arbiter (combinational):
  - Search starts at pointer+1 modulo N_REQ; the first requester with req_valid high wins.
  - req_ready[win] = can_accept. All other req_ready bits are 0. req_ready does not depend on rsp_ready beyond stall.
  - On a handshake (req_valid[w] & req_ready[w]), the pointer becomes w. Otherwise it holds.
- Stage 1 (issue register):
  - On handshake, capture op, id and the pre-scaled operand.
  - Sigmoid op: operand passes unchanged.
  - Tanh op: operand is 2*x, computed in DATA_WIDTH+1 bits and saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - sig_in is driven from the stage-1 register.
  - If there is no handshake and s1 advances, s1_valid <= 0. If stalled, s1 holds.
- Stage 2 (response register):
  - When ~stall, capture s1 contents: rsp_valid <= s1_valid.
  - Sigmoid op: rsp_data = sig_out.
  - Tanh op: rsp_data = (sig_out<<1) - 0x10, exact in DATA_WIDTH bits because sig_out is in [0, 0x10].
  - If stalled, all rsp_* outputs hold stable.
- Latency and throughput:
  - A handshake in cycle t gives rsp_valid in cycle t+2 when there is no stall.
  - Throughput is 1 op per cycle.
- Simultaneous events: an accept and a response handshake in the same cycle are both legal and both take effect.
- op_count increments on each rsp_valid & rsp_ready and saturates at all-ones.
- busy = s1_valid | rsp_valid.

Decomposition:
- Shared package holds:
  - localparam FRAC_BITS = 4.
  - ONE = 'h10.
  - OP_SIGMOID = 0, OP_TANH = 1.
  - the saturating-doubling function.
- One sub-module, rr_arbiter: parameterised on N_REQ. Inputs are req, advance and pointer state; outputs are a one-hot grant and the grant index.
- The sigmoid unit stays external and connects to sig_in/sig_out.

Test Plan:
- Single sigmoid: the bench models sig_out = lookup(sig_in). req0 sends op=0, data=0x08 in cycle t → sig_in=0x08 in t+1; with sig_out=0x0A, rsp_valid in t+2 with rsp_data=0x0A, rsp_id=0, rsp_op=0.
- Tanh transform: req1 sends op=1, data=0x08 → sig_in=0x10; with sig_out=0x0C, the result is rsp_data=0x08 and rsp_id=1.
- Tanh saturation: op=1, data=0x50 → sig_in=0x7F. data=0xA0 → sig_in=0x80. With sig_out=0x10 the result is 0x10; with sig_out=0x00 the result is 0xF0.
- Round-robin fairness: all three req_valid held high with rsp_ready=1 → grants 0,1,2,0,1,2 on consecutive cycles, and rsp_id follows the same order 2 cycles later.
- Backpressure: rsp_ready=0 for 3 cycles while rsp_valid=1 → rsp_data, rsp_id and rsp_op stable; req_ready all 0; s1 holds. On release, the queued op is presented the next cycle with no loss or duplication.
- Reset mid-stream and counter:
  - Assert rst while s1 and s2 are valid → rsp_valid=0, busy=0 and op_count=0 immediately (asynchronous).
  - After release, the first grant goes to requester 0.
  - Preload with force to 0xFFFE, then 3 completions → op_count = 0xFFFF.

Source files
------------

// File: rtl/act_unit_scheduler_pkg.sv
// Shared constants and fixed-point helpers for the activation-unit scheduler.
package act_unit_scheduler_pkg;

    localparam int FRAC_BITS = 4;
    localparam int ONE       = 1 << FRAC_BITS;   // 1.0 in Q3.4 = 'h10

    localparam logic OP_SIGMOID = 1'b0;
    localparam logic OP_TANH    = 1'b1;

    // Doubles a sign-extended operand and clamps it to the signed range of a
    // 'width'-bit word; the caller truncates the result back to 'width' bits.
    function automatic logic [31:0] sat_double(input logic signed [31:0] x,
                                               input int                 width);
        logic signed [32:0] dbl;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        dbl = {x, 1'b0};
        hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (width - 1));
        if (dbl > hi) begin
            return hi[31:0];
        end else if (dbl < lo) begin
            return lo[31:0];
        end
        return dbl[31:0];
    endfunction

endpackage

// File: rtl/act_unit_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 (mod N_REQ) and grants the first
// active requester. The one-hot grant is qualified by 'advance' so it can be
// used directly as the per-requester ready.
module act_unit_scheduler_rr_arbiter
    import act_unit_scheduler_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    logic found;

    // Rotating priority search starting just after the last winner.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % N_REQ]) begin
                found     = 1'b1;
                grant_idx = ID_W'((int'(ptr) + k) % N_REQ);
                grant[(int'(ptr) + k) % N_REQ] = advance;
            end
        end
    end

endmodule

// File: rtl/act_unit_scheduler.sv
// Shares one external combinational sigmoid unit among N_REQ GRU gate
// requesters. Tanh is built as 2*sigmoid(2x) - 1.0: the operand is doubled
// (saturating) on issue and the sigmoid result is post-processed on return.
// Two pipeline stages (issue, response) with valid/ready backpressure.
module act_unit_scheduler
    import act_unit_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 3,
    parameter int ID_W       = 2,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0]            req_op,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        rsp_op,
    output logic [DATA_WIDTH-1:0]       sig_in,
    input  logic [DATA_WIDTH-1:0]       sig_out,
    output logic                        busy,
    output logic [CNT_W-1:0]            op_count
);

    logic                  stall, can_accept, handshake;
    logic [N_REQ-1:0]      grant;
    logic [ID_W-1:0]       grant_idx;
    logic [DATA_WIDTH-1:0] sel_data, post_tanh;
    logic                  sel_op;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_op_q, s1_op_d;
    logic [ID_W-1:0]       s1_id_q, s1_id_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_op_q, rsp_op_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]      op_count_q, op_count_d;

    // A held response blocks the whole pipe; otherwise both stages advance.
    assign stall      = rsp_valid_q & ~rsp_ready;
    assign can_accept = ~stall;

    act_unit_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (req_valid),
        .advance   (can_accept),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign handshake = |grant;

    // Select the winning requester's operand and op code.
    always_comb begin
        sel_data = '0;
        sel_op   = OP_SIGMOID;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_op   = req_op[i];
            end
        end
    end

    // Issue stage and round-robin pointer: capture the pre-scaled operand on accept.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_id_d    = s1_id_q;
        s1_data_d  = s1_data_q;
        ptr_d      = handshake ? grant_idx : ptr_q;
        if (!stall) begin
            s1_valid_d = handshake;
            if (handshake) begin
                s1_op_d   = sel_op;
                s1_id_d   = grant_idx;
                s1_data_d = (sel_op == OP_TANH)
                          ? DATA_WIDTH'(sat_double(32'(signed'(sel_data)), DATA_WIDTH))
                          : sel_data;
            end
        end
    end

    // 2*s - 1.0 is exact in DATA_WIDTH bits because s lies in [0, 1.0].
    assign post_tanh = DATA_WIDTH'({sig_out, 1'b0}) - DATA_WIDTH'(ONE);

    // Response stage and completion counter: outputs hold while stalled.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_op_d    = rsp_op_q;
        op_count_d  = op_count_q;
        if (!stall) begin
            rsp_valid_d = s1_valid_q;
            rsp_data_d  = (s1_op_q == OP_TANH) ? post_tanh : sig_out;
            rsp_id_d    = s1_id_q;
            rsp_op_d    = s1_op_q;
        end
        if (rsp_valid_q && rsp_ready && !(&op_count_q)) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    // State registers; reset drops any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_SIGMOID;
            s1_id_q     <= '0;
            s1_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= OP_SIGMOID;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            ptr_q       <= ID_W'(N_REQ - 1);
            op_count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_id_q     <= s1_id_d;
            s1_data_q   <= s1_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_op_q    <= rsp_op_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            ptr_q       <= ptr_d;
            op_count_q  <= op_count_d;
        end
    end

    assign sig_in    = s1_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_op    = rsp_op_q;
    assign busy      = s1_valid_q | rsp_valid_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_act_unit_scheduler.sv
// Directed bench for act_unit_scheduler with a scoreboard of expected
// responses and a behavioural model of the shared sigmoid unit.
module tb_act_unit_scheduler;

    localparam int DW = 8;
    localparam int NR = 3;
    localparam int IW = 2;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready, req_op;
    logic [NR*DW-1:0]  req_data;
    logic              rsp_valid, rsp_ready, rsp_op, busy;
    logic [DW-1:0]     rsp_data, sig_in, sig_out;
    logic [IW-1:0]     rsp_id;
    logic [CW-1:0]     op_count;

    typedef struct packed {
        logic [IW-1:0] id;
        logic          op;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   n_done   = 0;

    always #5 clk = ~clk;

    act_unit_scheduler #(
        .DATA_WIDTH (DW),
        .N_REQ      (NR),
        .ID_W       (IW),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_op    (rsp_op),
        .sig_in    (sig_in),
        .sig_out   (sig_out),
        .busy      (busy),
        .op_count  (op_count)
    );

    // Sigmoid unit model: fixed points used by the directed cases, coarse ramp elsewhere.
    function automatic logic [DW-1:0] model_sig(input logic [DW-1:0] x);
        int v;
        case (x)
            8'h08:   return 8'h0A;
            8'h10:   return 8'h0C;
            8'h7F:   return 8'h10;
            8'h80:   return 8'h00;
            default: begin
                v = 8 + int'($signed(x)) / 4;
                if (v < 0)  v = 0;
                if (v > 16) v = 16;
                return DW'(v);
            end
        endcase
    endfunction

    function automatic logic [DW-1:0] sat2(input logic [DW-1:0] x);
        int v;
        v = 2 * int'($signed(x));
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return DW'(v);
    endfunction

    function automatic logic [DW-1:0] exp_result(input logic op, input logic [DW-1:0] x);
        logic [DW-1:0] s;
        s = model_sig(op ? sat2(x) : x);
        return op ? DW'({s, 1'b0} - 9'h010) : s;
    endfunction

    assign sig_out = model_sig(sig_in);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic op, input logic [DW-1:0] d);
        req_op[i]            = op;
        req_data[i*DW +: DW] = d;
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'(1));
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_rsp_data", 32'(rsp_data), 32'(mon_e.data));
                    check("sb_rsp_id",   32'(rsp_id),   32'(mon_e.id));
                    check("sb_rsp_op",   32'(rsp_op),   32'(mon_e.op));
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_e.id   = IW'(i);
                    mon_e.op   = req_op[i];
                    mon_e.data = exp_result(req_op[i], req_data[i*DW +: DW]);
                    sb.push_back(mon_e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_op_count",  32'(op_count),  32'(0));
        check("rst_sig_in",    32'(sig_in),    32'(0));
        check("rst_rsp_data",  32'(rsp_data),  32'(0));
        check("rst_rsp_id",    32'(rsp_id),    32'(0));
        rst = 1'b0;
        tick();

        // Single sigmoid from requester 0.
        set_req(0, 1'b0, 8'h08);
        req_valid = 3'b001;
        #1;
        check("sig_ready", 32'(req_ready), 32'(3'b001));
        tick();
        req_valid = '0;
        check("sig_sig_in", 32'(sig_in),    32'(8'h08));
        check("sig_busy",   32'(busy),      32'(1));
        check("sig_lat1",   32'(rsp_valid), 32'(0));
        tick();
        check("sig_valid", 32'(rsp_valid), 32'(1));
        check("sig_data",  32'(rsp_data),  32'(8'h0A));
        check("sig_id",    32'(rsp_id),    32'(0));
        check("sig_op",    32'(rsp_op),    32'(0));
        tick();
        check("sig_done", 32'(rsp_valid), 32'(0));
        check("sig_idle", 32'(busy),      32'(0));

        // Tanh from requester 1.
        set_req(1, 1'b1, 8'h08);
        req_valid = 3'b010;
        #1;
        check("tanh_ready", 32'(req_ready), 32'(3'b010));
        tick();
        req_valid = '0;
        check("tanh_sig_in", 32'(sig_in), 32'(8'h10));
        tick();
        check("tanh_valid", 32'(rsp_valid), 32'(1));
        check("tanh_data",  32'(rsp_data),  32'(8'h08));
        check("tanh_id",    32'(rsp_id),    32'(1));
        check("tanh_op",    32'(rsp_op),    32'(1));
        tick();

        // Tanh pre-scale saturation, both directions.
        set_req(2, 1'b1, 8'h50);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        check("sat_hi_sig_in", 32'(sig_in), 32'(8'h7F));
        tick();
        check("sat_hi_data", 32'(rsp_data), 32'(8'h10));
        check("sat_hi_id",   32'(rsp_id),   32'(2));
        set_req(2, 1'b1, 8'hA0);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        check("sat_lo_sig_in", 32'(sig_in), 32'(8'h80));
        tick();
        check("sat_lo_data", 32'(rsp_data), 32'(8'hF0));
        check("sat_lo_op",   32'(rsp_op),   32'(1));
        tick();

        // Round-robin with all requesters active.
        set_req(0, 1'b0, 8'h00);
        set_req(1, 1'b0, 8'h10);
        set_req(2, 1'b0, 8'hF0);
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_grant", 32'(req_ready), 32'(1 << (i % 3)));
            if (i >= 2) begin
                check("rr_rsp_valid", 32'(rsp_valid), 32'(1));
                check("rr_rsp_id",    32'(rsp_id),    32'((i - 2) % 3));
            end
            tick();
        end
        req_valid = '0;
        check("rr_rsp_id_tail0", 32'(rsp_id), 32'(1));
        tick();
        check("rr_rsp_id_tail1", 32'(rsp_id), 32'(2));
        tick();
        check("rr_drained", 32'(rsp_valid), 32'(0));

        // Backpressure: hold the response for three cycles.
        set_req(0, 1'b0, 8'h08);
        set_req(1, 1'b1, 8'h08);
        req_valid = 3'b011;
        #1;
        check("bp_grant0", 32'(req_ready), 32'(3'b001));
        tick();
        check("bp_grant1", 32'(req_ready), 32'(3'b010));
        tick();
        rsp_ready = 1'b0;
        set_req(0, 1'b0, 8'h10);
        req_valid = 3'b001;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid",   32'(rsp_valid), 32'(1));
            check("bp_data",    32'(rsp_data),  32'(8'h0A));
            check("bp_id",      32'(rsp_id),    32'(0));
            check("bp_op",      32'(rsp_op),    32'(0));
            check("bp_no_rdy",  32'(req_ready), 32'(0));
            check("bp_s1_hold", 32'(sig_in),    32'(8'h10));
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_rel_data",  32'(rsp_data),  32'(8'h0A));
        check("bp_rel_ready", 32'(req_ready), 32'(3'b001));
        tick();
        req_valid = '0;
        check("bp_next_valid", 32'(rsp_valid), 32'(1));
        check("bp_next_data",  32'(rsp_data),  32'(8'h08));
        check("bp_next_id",    32'(rsp_id),    32'(1));
        tick();
        check("bp_last_data", 32'(rsp_data), 32'(8'h0C));
        check("bp_last_id",   32'(rsp_id),   32'(0));
        tick();
        check("bp_drained", 32'(rsp_valid), 32'(0));
        check("cnt_pre_rst", 32'(op_count), 32'(n_done));
        check("sb_empty_pre_rst", 32'(sb.size()), 32'(0));

        // Reset with both stages occupied.
        req_valid = 3'b111;
        repeat (3) tick();
        req_valid = '0;
        check("pre_rst_busy",  32'(busy),      32'(1));
        check("pre_rst_valid", 32'(rsp_valid), 32'(1));
        #1;
        rst = 1'b1;
        sb.delete();
        n_done = 0;
        #1;
        check("arst_valid",    32'(rsp_valid), 32'(0));
        check("arst_busy",     32'(busy),      32'(0));
        check("arst_op_count", 32'(op_count),  32'(0));
        check("arst_sig_in",   32'(sig_in),    32'(0));
        tick();
        rst = 1'b0;
        req_valid = 3'b111;
        #1;
        check("post_rst_grant", 32'(req_ready), 32'(3'b001));
        tick();
        req_valid = '0;
        tick();
        tick();
        check("post_rst_count", 32'(op_count), 32'(1));

        // Counter saturation.
        force dut.op_count_q = 16'hFFFE;
        #1;
        release dut.op_count_q;
        check("cnt_preload", 32'(op_count), 32'(16'hFFFE));
        req_valid = 3'b111;
        repeat (3) tick();
        req_valid = '0;
        check("cnt_reach_max", 32'(op_count), 32'(16'hFFFF));
        repeat (3) tick();
        check("cnt_saturated", 32'(op_count), 32'(16'hFFFF));
        check("sb_empty_end",  32'(sb.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
